// File: rtl/block_averager_if.sv
// Sample-in / block-result-out bundle between the adder stage and the block averager.
// The averager sits on the slave side; the upstream driver is the master.
interface block_averager_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_LOG2_LEN = 8
);
    logic signed [DATA_WIDTH-1:0]              i_data;
    logic                                      i_valid;
    logic signed [DATA_WIDTH+MAX_LOG2_LEN-1:0] o_sum;
    logic signed [DATA_WIDTH-1:0]              o_mean;
    logic                                      o_valid;
    logic                                      o_busy;

    modport master (
        output i_data, i_valid,
        input  o_sum, o_mean, o_valid, o_busy
    );

    modport slave (
        input  i_data, i_valid,
        output o_sum, o_mean, o_valid, o_busy
    );
endinterface

// File: rtl/block_averager.sv
// Accumulates blocks of 2^L valid samples and emits the full block sum
// and its floored mean, each with a single-cycle valid pulse.
module block_averager #(
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_LOG2_LEN = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic [3:0] i_log2_len,
    block_averager_if.slave s_if
);
    localparam int AW = DATA_WIDTH + MAX_LOG2_LEN;
    localparam int CW = MAX_LOG2_LEN + 1;

    typedef enum logic {S_IDLE, S_ACCUM} state_t;

    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        if (len > 4'(MAX_LOG2_LEN))
            return 4'(MAX_LOG2_LEN);
        return len;
    endfunction

    function automatic logic signed [AW-1:0] sext(input logic signed [DATA_WIDTH-1:0] d);
        return {{MAX_LOG2_LEN{d[DATA_WIDTH-1]}}, d};
    endfunction

    // Arithmetic shift floors toward minus infinity; the result always fits DATA_WIDTH.
    function automatic logic signed [DATA_WIDTH-1:0] floor_mean(
        input logic signed [AW-1:0] total,
        input logic [3:0]           len
    );
        return DATA_WIDTH'(total >>> len);
    endfunction

    state_t                       r_state, w_state_nxt;
    logic [CW-1:0]                r_count;
    logic [3:0]                   r_len;
    logic signed [AW-1:0]         r_acc;
    logic signed [AW-1:0]         r_sum;
    logic signed [DATA_WIDTH-1:0] r_mean;
    logic                         r_valid;
    logic                         r_busy;

    logic                         w_take;
    logic                         w_last;
    logic [3:0]                   w_len_start;
    logic [3:0]                   w_len;
    logic signed [AW-1:0]         w_base;
    logic signed [AW-1:0]         w_total;
    logic [CW-1:0]                w_cnt_inc;
    logic [CW-1:0]                w_blk_len;
    logic                         w_valid_nxt;
    logic                         w_busy_nxt;

    // A sample taken in IDLE starts a fresh block: it latches L and loads rather than adds.
    always_comb begin
        w_take      = i_enable & s_if.i_valid;
        w_len_start = clamp_len(i_log2_len);
        w_len       = (r_state == S_IDLE) ? w_len_start : r_len;
        w_base      = (r_state == S_IDLE) ? '0 : r_acc;
        w_total     = w_base + sext(s_if.i_data);
        w_cnt_inc   = (r_state == S_IDLE) ? CW'(1) : r_count + CW'(1);
        w_blk_len   = CW'(1) << w_len;
        w_last      = w_take && (w_cnt_inc == w_blk_len);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!i_enable)
            w_state_nxt = S_IDLE;
        else if (w_take)
            w_state_nxt = w_last ? S_IDLE : S_ACCUM;
    end

    always_comb begin
        w_valid_nxt = w_last;
        w_busy_nxt  = (w_state_nxt == S_ACCUM);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
            r_len   <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_mean  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            if (!i_enable) begin
                r_count <= '0;
            end else if (w_take) begin
                if (r_state == S_IDLE)
                    r_len <= w_len_start;
                if (w_last) begin
                    r_count <= '0;
                    r_sum   <= w_total;
                    r_mean  <= floor_mean(w_total, w_len);
                end else begin
                    r_count <= w_cnt_inc;
                    r_acc   <= w_total;
                end
            end
        end
    end

    assign s_if.o_sum   = r_sum;
    assign s_if.o_mean  = r_mean;
    assign s_if.o_valid = r_valid;
    assign s_if.o_busy  = r_busy;
endmodule

// File: tb/tb_block_averager.sv
// Bench for block_averager: directed scenarios plus random traffic, checked by a
// queue-based scoreboard fed from a block-level reference model.
module tb_block_averager;
    localparam int DW = 32;
    localparam int ML = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] l2;

    always #5 clk = ~clk;

    block_averager_if #(.DATA_WIDTH(DW), .MAX_LOG2_LEN(ML)) bif ();

    block_averager #(.DATA_WIDTH(DW), .MAX_LOG2_LEN(ML)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_enable   (en),
        .i_log2_len (l2),
        .s_if       (bif)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint sum;
        longint mean;
        int     cyc;
    } exp_t;

    exp_t   sb[$];
    int     n_tests = 0;
    int     n_fail  = 0;

    int     m_cnt = 0;
    int     m_L   = 0;
    longint m_sum = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic longint floor_div(input longint s, input longint n);
        longint q;
        q = s / n;
        if ((s % n) != 0 && s < 0)
            q = q - 1;
        return q;
    endfunction

    // Block-level model: collect samples, and once a block holds N of them emit sum and floor(sum/N).
    task automatic model_sample(input longint d);
        exp_t e;
        if (m_cnt == 0) begin
            m_L   = (int'(l2) > ML) ? ML : int'(l2);
            m_sum = 0;
        end
        m_sum += d;
        m_cnt++;
        if (m_cnt == (1 << m_L)) begin
            e.sum  = m_sum;
            e.mean = floor_div(m_sum, longint'(1) << m_L);
            e.cyc  = cyc;
            sb.push_back(e);
            m_cnt = 0;
        end
    endtask

    task automatic send(input logic signed [DW-1:0] d, input int gap);
        bif.i_valid = 1'b1;
        bif.i_data  = d;
        @(posedge clk); #1;
        model_sample(longint'(d));
        bif.i_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drop_enable(input int cycles, input bit junk);
        en = 1'b0;
        repeat (cycles) begin
            bif.i_valid = junk;
            bif.i_data  = $urandom;
            @(posedge clk); #1;
        end
        m_cnt = 0;
        bif.i_valid = 1'b0;
        en = 1'b1;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() > 0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected results never appeared, required 0 outstanding", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_sum"},   longint'(bif.o_sum),   0);
        check({tag, "_mean"},  longint'(bif.o_mean),  0);
        check({tag, "_valid"}, longint'(bif.o_valid), 0);
        check({tag, "_busy"},  longint'(bif.o_busy),  0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bif.o_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_valid: got o_valid=1, expected 0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("sum",     longint'(bif.o_sum),  e.sum);
                check("mean",    longint'(bif.o_mean), e.mean);
                check("latency", longint'(cyc),        longint'(e.cyc));
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, required completion before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        en          = 1'b0;
        l2          = 4'd0;
        bif.i_valid = 1'b0;
        bif.i_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero_outputs("reset");
        en = 1'b1;

        // L = 2 with sparse samples
        l2 = 4'd2;
        send(-77, 15);
        check("busy_mid_block", longint'(bif.o_busy), 1);
        send(-76, 15);
        send(-75, 15);
        check("busy_before_end", longint'(bif.o_busy), 1);
        send(-74, 0);
        wait_drain();
        check("l2_sum_const",  longint'(bif.o_sum),  -302);
        check("l2_mean_const", longint'(bif.o_mean), -76);
        check("busy_after_end", longint'(bif.o_busy), 0);

        // L = 0 passthrough
        l2 = 4'd0;
        send(5, 0);
        send(-3, 0);
        send(7, 0);
        wait_drain();
        check("l0_last_mean", longint'(bif.o_mean), 7);
        check("l0_busy", longint'(bif.o_busy), 0);

        // Extremes; the second run requests 15 and relies on clamping to 8
        l2 = 4'd8;
        repeat (256) send(32'sh80000000, 0);
        wait_drain();
        check("min_sum_const",  longint'(bif.o_sum),  -(longint'(1) << 39));
        check("min_mean_const", longint'(bif.o_mean), -(longint'(1) << 31));
        l2 = 4'd15;
        repeat (256) send(32'sh7fffffff, 0);
        wait_drain();
        check("max_mean_const", longint'(bif.o_mean), (longint'(1) << 31) - 1);

        // Length change mid-block
        l2 = 4'd2;
        send(1, 0);
        send(2, 0);
        l2 = 4'd1;
        send(3, 0);
        check("lenchg_busy", longint'(bif.o_busy), 1);
        send(4, 0);
        send(5, 0);
        send(6, 0);
        wait_drain();
        check("lenchg_sum_const", longint'(bif.o_sum), 11);

        // Enable drop discards the partial block
        l2 = 4'd2;
        send(7, 0);
        send(7, 0);
        send(7, 0);
        drop_enable(2, 1'b0);
        check("endrop_busy", longint'(bif.o_busy), 0);
        repeat (4) send(10, 0);
        wait_drain();
        check("endrop_sum_const",  longint'(bif.o_sum),  40);
        check("endrop_mean_const", longint'(bif.o_mean), 10);

        // Reset mid-block
        send(9, 0);
        send(9, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        m_cnt = 0;
        check_zero_outputs("midreset");
        repeat (4) send(1, 0);
        wait_drain();
        check("rst_sum_const",  longint'(bif.o_sum),  4);
        check("rst_mean_const", longint'(bif.o_mean), 1);

        // Random traffic: random data, gaps, lengths (including clamped ones) and enable drops
        l2 = 4'd3;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0)
                l2 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0)
                drop_enable($urandom_range(1, 2), 1'b1);
            else
                send($urandom, $urandom_range(0, 2));
        end
        drop_enable(1, 1'b0);
        wait_drain();
        repeat (5) begin
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
